chacha20_stream_ctrl: RTL and testbench

//   Streaming front/back end for the ChaCha20 block core.

---
 rtl/chacha20_stream_ctrl_if.sv | 25 ++
 rtl/chacha20_stream_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_chacha20_stream_ctrl.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chacha20_stream_ctrl_if.sv
// Word-stream bundle for the ChaCha20 stream controller.
// The input stream (s_*) carries plaintext or ciphertext words toward the core.
// The output stream (m_*) carries the XORed result words away from it.
// master: the system side that feeds s_* and consumes m_*.
// slave:  the controller itself.
interface chacha20_stream_ctrl_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/chacha20_stream_ctrl.sv
// Streaming front/back end for a ChaCha20 block core.
// The controller collects up to 16 input words into a 512-bit block and kicks the core
// once per block, advancing the block counter after each block. It then replays the
// core result word by word on the output stream. The core only XORs keystream, so the
// same path serves both encryption and decryption.
module chacha20_stream_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_load,
  input  logic [255:0]           cfg_key,
  input  logic [95:0]            cfg_nonce,
  input  logic [31:0]            cfg_counter,
  chacha20_stream_ctrl_if.slave  strm,
  output logic                   core_start,
  input  logic                   core_busy,
  input  logic                   core_done,
  output logic [255:0]           core_key,
  output logic [95:0]            core_nonce,
  output logic [31:0]            core_counter,
  output logic [511:0]           core_in_state,
  input  logic [511:0]           core_out_state,
  output logic                   busy,
  output logic                   err_overflow,
  output logic                   err_timeout
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  state_t state_reg, state_next;

  // Block buffer: element 0 occupies the top 32 bits, matching the core's word order.
  logic [0:15][31:0]   blk_buf_reg;
  logic [3:0]          widx_reg;
  logic [3:0]          ridx_reg;
  // Index of the final valid word in the block (number of words minus one).
  logic [3:0]          last_idx_reg;
  logic                last_seen_reg;
  logic [31:0]         blk_ctr_reg;
  logic [255:0]        key_reg;
  logic [95:0]         nonce_reg;
  logic [WAIT_W-1:0]   wait_cnt_reg;
  logic                err_overflow_reg;
  logic                err_timeout_reg;

  logic s_hs;
  logic m_hs;
  logic fill_end;
  logic drain_end;
  logic core_busy_unused;

  // The core's busy flag is informational only; the done pulse is what matters here.
  assign core_busy_unused = core_busy;

  assign s_hs      = strm.s_valid && (state_reg == ST_FILL);
  assign m_hs      = strm.m_ready && (state_reg == ST_DRAIN);
  assign fill_end  = s_hs && (strm.s_last || (widx_reg == 4'd15));
  assign drain_end = m_hs && (ridx_reg == last_idx_reg);

  assign strm.m_data   = blk_buf_reg[ridx_reg];
  assign core_key      = key_reg;
  assign core_nonce    = nonce_reg;
  assign core_counter  = blk_ctr_reg;
  assign core_in_state = blk_buf_reg;
  assign err_overflow  = err_overflow_reg;
  assign err_timeout   = err_timeout_reg;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode and per-state stream/core strobes.
  always_comb begin
    state_next   = state_reg;
    strm.s_ready = 1'b0;
    strm.m_valid = 1'b0;
    strm.m_last  = 1'b0;
    core_start   = 1'b0;
    busy         = 1'b1;
    case (state_reg)
      ST_IDLE: begin
        busy = 1'b0;
        if (cfg_load) state_next = ST_FILL;
      end
      ST_FILL: begin
        strm.s_ready = 1'b1;
        if (fill_end) state_next = ST_START;
      end
      ST_START: begin
        core_start = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_done) begin
          state_next = ST_DRAIN;
        end else if (wait_cnt_reg == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          state_next = ST_ERR;
        end
      end
      ST_DRAIN: begin
        strm.m_valid = 1'b1;
        strm.m_last  = last_seen_reg && (ridx_reg == last_idx_reg);
        if (drain_end) begin
          if (last_seen_reg) begin
            state_next = ST_IDLE;
          end else if (blk_ctr_reg == 32'hFFFF_FFFF) begin
            state_next = ST_ERR;
          end else begin
            state_next = ST_FILL;
          end
        end
      end
      ST_ERR: begin
        state_next = ST_ERR;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath: config latch, block packing/unpacking, counters and sticky errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_buf_reg      <= '0;
      widx_reg         <= '0;
      ridx_reg         <= '0;
      last_idx_reg     <= '0;
      last_seen_reg    <= 1'b0;
      blk_ctr_reg      <= '0;
      key_reg          <= '0;
      nonce_reg        <= '0;
      wait_cnt_reg     <= '0;
      err_overflow_reg <= 1'b0;
      err_timeout_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cfg_load) begin
            key_reg       <= cfg_key;
            nonce_reg     <= cfg_nonce;
            blk_ctr_reg   <= cfg_counter;
            blk_buf_reg   <= '0;
            widx_reg      <= '0;
            ridx_reg      <= '0;
            last_idx_reg  <= '0;
            last_seen_reg <= 1'b0;
          end
        end
        ST_FILL: begin
          if (s_hs) begin
            blk_buf_reg[widx_reg] <= strm.s_data;
            widx_reg              <= widx_reg + 4'd1;
            if (fill_end) begin
              last_idx_reg  <= widx_reg;
              last_seen_reg <= strm.s_last;
            end
          end
        end
        ST_START: begin
          wait_cnt_reg <= '0;
        end
        ST_WAIT: begin
          wait_cnt_reg <= wait_cnt_reg + 1'b1;
          if (core_done) begin
            blk_buf_reg <= core_out_state;
            ridx_reg    <= '0;
          end else if (state_next == ST_ERR) begin
            err_timeout_reg <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (m_hs) begin
            ridx_reg <= ridx_reg + 4'd1;
          end
          if (drain_end && !last_seen_reg) begin
            if (blk_ctr_reg == 32'hFFFF_FFFF) begin
              err_overflow_reg <= 1'b1;
            end else begin
              blk_ctr_reg <= blk_ctr_reg + 32'd1;
              blk_buf_reg <= '0;
              widx_reg    <= '0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chacha20_stream_ctrl.sv
// Self-checking bench for chacha20_stream_ctrl.
// A behavioural ChaCha20 core stub answers core_start pulses. A message-level model
// predicts every output word (input XOR keystream of block ctr0 + i/16) and every core
// invocation (counter and zero-padded input block). A single monitor compares them.
module tb_chacha20_stream_ctrl;
  typedef logic [15:0][31:0] st_t;
  typedef struct packed { logic [31:0] d; logic l; } out_t;
  typedef struct packed { logic [31:0] ctr; logic [511:0] blk; } blk_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_load = 1'b0;
  logic [255:0] cfg_key = '0;
  logic [95:0]  cfg_nonce = '0;
  logic [31:0]  cfg_counter = '0;
  logic         core_start, core_busy, core_done;
  logic [255:0] core_key;
  logic [95:0]  core_nonce;
  logic [31:0]  core_counter;
  logic [511:0] core_in_state, core_out_state;
  logic         busy, err_overflow, err_timeout;

  chacha20_stream_ctrl_if bus ();

  chacha20_stream_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_load(cfg_load), .cfg_key(cfg_key), .cfg_nonce(cfg_nonce), .cfg_counter(cfg_counter),
    .strm(bus),
    .core_start(core_start), .core_busy(core_busy), .core_done(core_done),
    .core_key(core_key), .core_nonce(core_nonce), .core_counter(core_counter),
    .core_in_state(core_in_state), .core_out_state(core_out_state),
    .busy(busy), .err_overflow(err_overflow), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int sink_mode = 0;      // 0 always ready, 1 random stalls, 2 never ready
  bit stub_hang = 1'b0;
  int start_cycles = 0;

  out_t          exp_out[$];
  blk_t          exp_blk[$];
  logic [31:0]   msg[$];
  logic [31:0]   got_log[$];
  logic [31:0]   ctr_log[$];
  logic [511:0]  stub_last_in;
  logic [255:0]  cur_key;
  logic [95:0]   cur_nonce;

  localparam logic [255:0] RFC_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [95:0]  RFC_NONCE = 96'h000000090000004a00000000;

  function automatic void chk(string nm, logic [511:0] act, logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] rotl(logic [31:0] x, int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] bswap(logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic st_t qr(st_t s, int a, int b, int c, int d);
    s[a] = s[a] + s[b]; s[d] = rotl(s[d] ^ s[a], 16);
    s[c] = s[c] + s[d]; s[b] = rotl(s[b] ^ s[c], 12);
    s[a] = s[a] + s[b]; s[d] = rotl(s[d] ^ s[a], 8);
    s[c] = s[c] + s[d]; s[b] = rotl(s[b] ^ s[c], 7);
    return s;
  endfunction

  // RFC 8439 block function; key and nonce are byte strings written MSB-first.
  function automatic st_t chacha(logic [255:0] k, logic [95:0] n, logic [31:0] c);
    st_t s0, x;
    s0[0] = 32'h61707865; s0[1] = 32'h3320646e; s0[2] = 32'h79622d32; s0[3] = 32'h6b206574;
    for (int j = 0; j < 8; j++) s0[4+j] = bswap(k[255-32*j -: 32]);
    s0[12] = c;
    for (int j = 0; j < 3; j++) s0[13+j] = bswap(n[95-32*j -: 32]);
    x = s0;
    for (int r = 0; r < 10; r++) begin
      x = qr(x, 0, 4, 8, 12); x = qr(x, 1, 5, 9, 13); x = qr(x, 2, 6, 10, 14); x = qr(x, 3, 7, 11, 15);
      x = qr(x, 0, 5, 10, 15); x = qr(x, 1, 6, 11, 12); x = qr(x, 2, 7, 8, 13); x = qr(x, 3, 4, 9, 14);
    end
    for (int i = 0; i < 16; i++) x[i] = x[i] + s0[i];
    return x;
  endfunction

  // Message-level model: predicts core invocations and output words for msg.
  task automatic model_msg(input logic [31:0] c0, output int nacc);
    int n, b, base, nw;
    bit last;
    logic [31:0] ctr;
    st_t ks;
    blk_t e;
    out_t o;
    n = msg.size(); b = 0; nacc = 0;
    forever begin
      base = 16 * b;
      nw = (n - base > 16) ? 16 : n - base;
      last = (base + nw == n);
      ctr = c0 + b;
      ks = chacha(cur_key, cur_nonce, ctr);
      e.ctr = ctr; e.blk = '0;
      for (int j = 0; j < nw; j++) begin
        e.blk[511-32*j -: 32] = msg[base+j];
        o.d = msg[base+j] ^ ks[j];
        o.l = last && (j == nw - 1);
        exp_out.push_back(o);
      end
      exp_blk.push_back(e);
      nacc += nw;
      if (last || ctr == 32'hFFFF_FFFF) break;
      b++;
    end
  endtask

  task automatic load_cfg(input logic [31:0] c0);
    int g = 0;
    @(negedge clk);
    while (busy && g < 1000) begin @(negedge clk); g++; end
    if (g >= 1000) chk("idle_before_load", busy, 0);
    cfg_key = cur_key; cfg_nonce = cur_nonce; cfg_counter = c0; cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  task automatic feed(input int nacc);
    int i = 0;
    int g = 0;
    while (i < nacc) begin
      @(negedge clk);
      bus.s_valid = ($urandom_range(0, 3) != 0);
      bus.s_data  = msg[i];
      bus.s_last  = (i == msg.size() - 1);
      if (bus.s_valid && bus.s_ready) begin
        i++; g = 0;
      end else if (++g > 2000) begin
        chk("s_ready_timeout", i, nacc);
        break;
      end
    end
    @(negedge clk);
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
  endtask

  task automatic wait_done(input bit want_ovf);
    int g = 0;
    while (!(exp_out.size() == 0 && (want_ovf ? err_overflow : !busy)) && g < 5000) begin
      @(negedge clk); g++;
    end
    if (g >= 5000) chk("drain_timeout", exp_out.size(), 0);
    chk("blocks_consumed", exp_blk.size(), 0);
  endtask

  task automatic run(input logic [31:0] c0, input bit want_ovf);
    int nacc;
    got_log.delete(); ctr_log.delete();
    load_cfg(c0);
    model_msg(c0, nacc);
    feed(nacc);
    wait_done(want_ovf);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    exp_out.delete(); exp_blk.delete();
    rst_n = 1'b1;
  endtask

  // Core stub: real ChaCha20 keystream XOR with a random latency.
  initial begin
    st_t ks;
    logic [511:0] o;
    blk_t b;
    int lat;
    core_done = 1'b0; core_busy = 1'b0; core_out_state = '0;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (rst_n && core_start) begin
        if (exp_blk.size() == 0) begin
          chk("unexpected_core_start", 1, 0);
        end else begin
          b = exp_blk.pop_front();
          chk("core_counter", core_counter, b.ctr);
          chk("core_in_state", core_in_state, b.blk);
        end
        ctr_log.push_back(core_counter);
        stub_last_in = core_in_state;
        ks = chacha(core_key, core_nonce, core_counter);
        for (int i = 0; i < 16; i++) o[511-32*i -: 32] = core_in_state[511-32*i -: 32] ^ ks[i];
        core_busy = 1'b1;
        lat = $urandom_range(1, 5);
        repeat (lat) @(negedge clk);
        core_busy = 1'b0;
        core_out_state = o;
        if (!stub_hang && rst_n) core_done = 1'b1;
      end
    end
  end

  // Output monitor: drives m_ready, checks every accepted word and stall stability.
  initial begin
    bit prev_stall = 1'b0;
    logic [31:0] prev_d = '0;
    logic prev_l = 1'b0;
    out_t e;
    bus.m_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        bus.m_ready = 1'b0;
      end else begin
        if (core_start) start_cycles++;
        case (sink_mode)
          0: bus.m_ready = 1'b1;
          1: bus.m_ready = ($urandom_range(0, 2) != 0);
          default: bus.m_ready = 1'b0;
        endcase
        if (prev_stall) begin
          chk("stall_valid", bus.m_valid, 1);
          chk("stall_data", bus.m_data, prev_d);
          chk("stall_last", bus.m_last, prev_l);
        end
        if (bus.m_valid) begin
          chk("no_overlap", bus.s_ready, 0);
          if (bus.m_ready) begin
            if (exp_out.size() == 0) begin
              chk("unexpected_word", 1, 0);
            end else begin
              e = exp_out.pop_front();
              chk("m_data", bus.m_data, e.d);
              chk("m_last", bus.m_last, e.l);
            end
            got_log.push_back(bus.m_data);
          end
          prev_stall = !bus.m_ready;
          prev_d = bus.m_data;
          prev_l = bus.m_last;
        end else begin
          prev_stall = 1'b0;
        end
      end
    end
  end

  // Global watchdog.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    st_t ks;
    int g, cnt, nacc, s0;
    logic [31:0] rt[$];
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_last", bus.m_last, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_overflow", err_overflow, 0);
    chk("rst_err_timeout", err_timeout, 0);
    chk("rst_core_in_state", core_in_state, 0);
    chk("rst_core_counter", core_counter, 0);
    chk("rst_core_key", core_key, 0);
    chk("rst_core_nonce", core_nonce, 0);
    rst_n = 1'b1;

    // Pin the keystream model against RFC 8439 block test vector.
    ks = chacha(RFC_KEY, RFC_NONCE, 32'd1);
    chk("model_ks0", ks[0], 32'he4e7f110);
    chk("model_ks15", ks[15], 32'h4e3c50a2);

    // s_valid in IDLE is ignored.
    @(negedge clk); bus.s_valid = 1'b1; bus.s_data = 32'h1234;
    @(negedge clk);
    chk("idle_s_ready", bus.s_ready, 0);
    bus.s_valid = 1'b0;

    // Test 1: RFC key/nonce, counter 1, 16 words of "ABCD".
    sink_mode = 0;
    cur_key = RFC_KEY; cur_nonce = RFC_NONCE;
    msg.delete();
    for (int i = 0; i < 16; i++) msg.push_back(32'h44434241);
    run(32'd1, 1'b0);
    chk("t1_count", got_log.size(), 16);
    chk("t1_word0", got_log[0], 32'ha0a4b351);
    chk("t1_word15", got_log[15], 32'h0a7f12e3);
    chk("t1_ctr", ctr_log[0], 1);

    // Test 2: feed the ciphertext back with the same config.
    rt = got_log;
    msg = rt;
    run(32'd1, 1'b0);
    for (int i = 0; i < 16; i++) chk("t2_roundtrip", got_log[i], 32'h44434241);

    // Test 3: short message, zero-padded block.
    msg.delete();
    for (int i = 0; i < 3; i++) msg.push_back($urandom);
    run(32'd7, 1'b0);
    chk("t3_count", got_log.size(), 3);
    chk("t3_pad_zero", stub_last_in[415:0], 0);

    // Test 4: 20 words across two blocks with random stalls.
    sink_mode = 1;
    msg.delete();
    for (int i = 0; i < 20; i++) msg.push_back($urandom);
    s0 = start_cycles;
    run(32'd1, 1'b0);
    chk("t4_starts", start_cycles - s0, 2);
    chk("t4_count", got_log.size(), 20);
    chk("t4_ctr0", ctr_log[0], 1);
    chk("t4_ctr1", ctr_log[1], 2);

    // Random messages, keys and counters.
    for (int t = 0; t < 6; t++) begin
      cur_key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      cur_nonce = {$urandom, $urandom, $urandom};
      msg.delete();
      for (int i = 0; i < $urandom_range(1, 40); i++) msg.push_back($urandom);
      run($urandom_range(0, 100000), 1'b0);
      chk("rand_count", got_log.size(), msg.size());
    end

    // Test 5: counter overflow after the first block.
    msg.delete();
    for (int i = 0; i < 17; i++) msg.push_back($urandom);
    run(32'hFFFF_FFFF, 1'b1);
    chk("t5_count", got_log.size(), 16);
    chk("t5_err_overflow", err_overflow, 1);
    bus.s_valid = 1'b1; bus.s_data = msg[16]; bus.s_last = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("t5_s_ready", bus.s_ready, 0);
    end
    chk("t5_m_valid", bus.m_valid, 0);
    chk("t5_err_timeout", err_timeout, 0);
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
    reset_dut();

    // Test 6a: core never finishes.
    sink_mode = 0;
    stub_hang = 1'b1;
    msg.delete();
    for (int i = 0; i < 16; i++) msg.push_back($urandom);
    load_cfg(32'd5);
    model_msg(32'd5, nacc);
    feed(nacc);
    g = 0;
    while (!core_start && g < 500) begin @(negedge clk); g++; end
    chk("t6_start_seen", core_start, 1);
    cnt = 0;
    while (!err_timeout && cnt < 400) begin @(negedge clk); cnt++; end
    chk("t6_timeout_cycles", cnt, 256);
    chk("t6_busy", busy, 1);
    chk("t6_s_ready", bus.s_ready, 0);
    chk("t6_m_valid", bus.m_valid, 0);
    chk("t6_err_overflow", err_overflow, 0);
    repeat (5) @(negedge clk);
    chk("t6_timeout_sticky", err_timeout, 1);
    stub_hang = 1'b0;
    reset_dut();
    chk("t6_timeout_cleared", err_timeout, 0);

    // Test 6b: asynchronous reset in the middle of DRAIN.
    sink_mode = 2;
    cur_key = {8{$urandom}} | 256'h1;
    msg.delete();
    for (int i = 0; i < 5; i++) msg.push_back($urandom);
    load_cfg(32'd9);
    model_msg(32'd9, nacc);
    feed(nacc);
    g = 0;
    while (!bus.m_valid && g < 300) begin @(negedge clk); g++; end
    chk("t6_in_drain", bus.m_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6r_m_valid", bus.m_valid, 0);
    chk("t6r_m_last", bus.m_last, 0);
    chk("t6r_m_data", bus.m_data, 0);
    chk("t6r_busy", busy, 0);
    chk("t6r_s_ready", bus.s_ready, 0);
    chk("t6r_core_start", core_start, 0);
    chk("t6r_core_key", core_key, 0);
    chk("t6r_core_counter", core_counter, 0);
    chk("t6r_core_in_state", core_in_state, 0);
    repeat (2) @(negedge clk);
    exp_out.delete(); exp_blk.delete();
    rst_n = 1'b1;
    sink_mode = 1;

    // Recovery run after the abort.
    msg.delete();
    for (int i = 0; i < 9; i++) msg.push_back($urandom);
    run(32'd3, 1'b0);
    chk("recover_count", got_log.size(), 9);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
